vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster engine with an Avalon-MM register
//                slave. Generates pixel-rate sync/blank timing, fetches pixels
//                one pixel-time ahead through pix_req/pix_x/pix_y, counts
//                frames and raises a sticky frame-done interrupt.
//                Optional build macro VGA_TEST_PATTERN_EN adds CTRL[5], an
//                8-bar colour test pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int COORD_W  = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               pix_req,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    input  logic [23:0]        pix_rgb,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_clk,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               irq,
    output logic [1:0]         aux_ctrl
);

    localparam int c_HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);

    localparam logic [COORD_W-1:0] c_H_ACT_END  = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_H_FP_END   = COORD_W'(H_ACTIVE + H_FP - 1);
    localparam logic [COORD_W-1:0] c_H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] c_H_TOT_END  = COORD_W'(c_HT - 1);
    localparam logic [COORD_W-1:0] c_V_ACT_END  = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_V_FP_END   = COORD_W'(V_ACTIVE + V_FP - 1);
    localparam logic [COORD_W-1:0] c_V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] c_V_TOT_END  = COORD_W'(c_VT - 1);

    // Region states are numbered in scan order so the next state is state+1.
    localparam logic [1:0] c_ST_ACTIVE = 2'd0;
    localparam logic [1:0] c_ST_FP     = 2'd1;
    localparam logic [1:0] c_ST_SYNC   = 2'd2;
    localparam logic [1:0] c_ST_BP     = 2'd3;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_FCNT   = 2'd2;
    localparam logic [1:0] c_ADDR_BG     = 2'd3;

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_CTRL_W = 6;
`else
    localparam int c_CTRL_W = 5;
`endif

    logic [c_DIV_W-1:0]  r_div;
    logic                r_vga_clk;
    logic [c_CTRL_W-1:0] r_ctrl;
    logic [23:0]         r_bg;
    logic                r_frame_done;
    logic [15:0]         r_frame_cnt;
    logic                r_irq;
    logic [31:0]         r_readdata;
    logic                r_run;
    logic [COORD_W-1:0]  r_h;
    logic [COORD_W-1:0]  r_v;
    logic [1:0]          r_h_state;
    logic [1:0]          r_v_state;
    logic                r_pix_req;
    logic [COORD_W-1:0]  r_pix_x;
    logic [COORD_W-1:0]  r_pix_y;
    logic                r_s1_active;
    logic                r_s1_hs;
    logic                r_s1_vs;
    logic [23:0]         r_rgb;
    logic                r_blank_n;
    logic                r_hs;
    logic                r_vs;

    logic                w_pe;
    logic [c_DIV_W-1:0]  w_div_next;
    logic                w_enable;
    logic                w_irq_en;
    logic                w_src;
    logic                w_pattern;
    logic [23:0]         w_bar_rgb;
    logic                w_step;
    logic [COORD_W-1:0]  w_h_last;
    logic [COORD_W-1:0]  w_v_last;
    logic                w_h_wrap;
    logic                w_frame_end;
    logic                w_in_active;
    logic                w_in_vblank;
    logic [23:0]         w_colour;
    logic                w_status_w1c;
    logic                w_unused_wdata;

    assign w_enable     = r_ctrl[0];
    assign w_irq_en     = r_ctrl[1];
    assign w_src        = r_ctrl[4];
    assign w_pe         = (r_div == c_DIV_LAST);
    assign w_div_next   = w_pe ? '0 : r_div + 1'b1;
    assign w_step       = w_pe & w_enable & r_run;
    assign w_h_wrap     = (r_h == c_H_TOT_END);
    assign w_frame_end  = w_h_wrap & (r_v == c_V_TOT_END);
    assign w_in_active  = (r_h_state == c_ST_ACTIVE) & (r_v_state == c_ST_ACTIVE);
    assign w_in_vblank  = (r_v_state != c_ST_ACTIVE);
    assign w_status_w1c = avs_write & (avs_address == c_ADDR_STATUS) & avs_writedata[0];
    assign w_colour     = w_pattern ? w_bar_rgb : (w_src ? pix_rgb : r_bg);
    assign w_unused_wdata = &{1'b0, avs_writedata[31:24]};

`ifdef VGA_TEST_PATTERN_EN
    // Bars are H_ACTIVE/8 wide; columns past the eighth bar stay black.
    localparam int c_BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic [COORD_W-1:0] w_bar_q;
    logic [2:0]         w_bar_idx;
    assign w_pattern = r_ctrl[5];
    assign w_bar_q   = r_pix_x / COORD_W'(c_BAR_W);
    assign w_bar_idx = (w_bar_q > COORD_W'(7)) ? 3'd7 : w_bar_q[2:0];
    // White, yellow, cyan, green, magenta, red, blue, black reduce to
    // R = ~idx[1], G = ~idx[2], B = ~idx[0].
    assign w_bar_rgb = {{8{~w_bar_idx[1]}}, {8{~w_bar_idx[2]}}, {8{~w_bar_idx[0]}}};
`else
    assign w_pattern = 1'b0;
    assign w_bar_rgb = 24'h0;
`endif

    // Last count of the current region, used to step the region FSMs.
    always_comb begin
        w_h_last = c_H_TOT_END;
        w_v_last = c_V_TOT_END;
        case (r_h_state)
            c_ST_ACTIVE: w_h_last = c_H_ACT_END;
            c_ST_FP:     w_h_last = c_H_FP_END;
            c_ST_SYNC:   w_h_last = c_H_SYNC_END;
            default:     w_h_last = c_H_TOT_END;
        endcase
        case (r_v_state)
            c_ST_ACTIVE: w_v_last = c_V_ACT_END;
            c_ST_FP:     w_v_last = c_V_FP_END;
            c_ST_SYNC:   w_v_last = c_V_SYNC_END;
            default:     w_v_last = c_V_TOT_END;
        endcase
    end

    // Free-running pixel divider; vga_clk rises in the middle of each pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div     <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_vga_clk <= w_enable & (w_div_next >= c_DIV_HALF);
        end
    end

    // Raster counters and region FSMs; the first pe after enable arms the scan at 0,0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= 1'b0;
            r_h       <= '0;
            r_v       <= '0;
            r_h_state <= c_ST_ACTIVE;
            r_v_state <= c_ST_ACTIVE;
        end else if (w_pe) begin
            if (!w_enable) begin
                r_run     <= 1'b0;
                r_h       <= '0;
                r_v       <= '0;
                r_h_state <= c_ST_ACTIVE;
                r_v_state <= c_ST_ACTIVE;
            end else if (!r_run) begin
                r_run <= 1'b1;
            end else begin
                if (r_h == w_h_last) begin
                    r_h_state <= r_h_state + 2'd1;
                end
                if (w_h_wrap) begin
                    r_h <= '0;
                    if (r_v == w_v_last) begin
                        r_v_state <= r_v_state + 2'd1;
                    end
                    r_v <= (r_v == c_V_TOT_END) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    // Fetch stage: request the pixel one pixel-time before it is displayed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_req   <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
        end else if (w_pe) begin
            if (!w_enable || !r_run) begin
                r_pix_req   <= 1'b0;
                r_pix_x     <= '0;
                r_pix_y     <= '0;
                r_s1_active <= 1'b0;
                r_s1_hs     <= 1'b0;
                r_s1_vs     <= 1'b0;
            end else begin
                r_pix_req   <= w_in_active & ~w_pattern;
                r_pix_x     <= r_h;
                r_pix_y     <= r_v;
                r_s1_active <= w_in_active;
                r_s1_hs     <= (r_h_state == c_ST_SYNC);
                r_s1_vs     <= (r_v_state == c_ST_SYNC);
            end
        end
    end

    // Display stage: capture colour and emit syncs aligned with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb     <= '0;
            r_blank_n <= 1'b0;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
        end else if (w_pe) begin
            if (!w_enable) begin
                r_rgb     <= '0;
                r_blank_n <= 1'b0;
                r_hs      <= ~SYNC_POL;
                r_vs      <= ~SYNC_POL;
            end else begin
                r_rgb     <= r_s1_active ? w_colour : '0;
                r_blank_n <= r_s1_active;
                r_hs      <= r_s1_hs ? SYNC_POL : ~SYNC_POL;
                r_vs      <= r_s1_vs ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    // Writable control and background-colour registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
            r_bg   <= '0;
        end else if (avs_write) begin
            case (avs_address)
                c_ADDR_CTRL: r_ctrl <= avs_writedata[c_CTRL_W-1:0];
                c_ADDR_BG:   r_bg   <= avs_writedata[23:0];
                default:     ;
            endcase
        end
    end

    // Frame-done is sticky; a set in the same cycle as a W1C takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_step && w_frame_end) begin
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
            end else if (w_status_w1c) begin
                r_frame_done <= 1'b0;
            end
            r_irq <= r_frame_done & w_irq_en;
        end
    end

    // Registered read mux, one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                c_ADDR_CTRL:   r_readdata <= 32'(r_ctrl);
                c_ADDR_STATUS: r_readdata <= {30'd0, w_in_vblank, r_frame_done};
                c_ADDR_FCNT:   r_readdata <= {16'd0, r_frame_cnt};
                default:       r_readdata <= {8'd0, r_bg};
            endcase
        end
    end

    assign avs_readdata = r_readdata;
    assign pix_req      = r_pix_req;
    assign pix_x        = r_pix_x;
    assign pix_y        = r_pix_y;
    assign vga_r        = r_rgb[23:16];
    assign vga_g        = r_rgb[15:8];
    assign vga_b        = r_rgb[7:0];
    assign vga_clk      = r_vga_clk;
    assign vga_hs       = r_hs;
    assign vga_vs       = r_vs;
    assign vga_blank_n  = r_blank_n;
    assign vga_sync_n   = 1'b0;
    assign irq          = r_irq;
    assign aux_ctrl     = r_ctrl[3:2];

endmodule
`default_nettype wire
